pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, address loaded into the PC on reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1, hold PC this cycle (hazard unit).
REQ-005 SHALL have port redirect_valid, input, 1, branch/jump/jr target presented this cycle.
REQ-006 SHALL have port redirect_target, input, 32, next fetch address when redirect_valid=1.
REQ-007 SHALL have port pc, output, 32, current fetch address (registered).
REQ-008 SHALL have port pc_plus4, output, 32, pc+4 (combinational).
REQ-009 SHALL have port pc_plus8, output, 32, pc+8 (combinational), the jal/jalr link value.
REQ-010 SHALL have port redirect_pending, output, 1, a redirect is buffered awaiting stall release.
REQ-011 SHALL have port misalign_err, output, 1, applied target had nonzero bits [1:0].

Function
REQ-012 SHALL, when stall=0 and redirect_valid=1, load pc<=redirect_target at the next edge (1-cycle latency).
REQ-013 SHALL, when stall=0, redirect_valid=0 and redirect_pending=1, load the buffered target and clear redirect_pending.
REQ-014 SHALL, when stall=0 with no live or buffered redirect, load pc<=pc_plus4.
REQ-015 SHALL, when stall=1, hold pc unchanged.
REQ-016 SHALL, when stall=1 and redirect_valid=1, buffer redirect_target and set redirect_pending; a later redirect during the same stall overwrites the buffer.
REQ-017 SHALL give a live redirect priority over a buffered one when both exist with stall=0; the buffer is then cleared.
REQ-018 SHALL compute pc_plus4/pc_plus8 modulo 2^32 (pc=32'hFFFF_FFFC gives pc_plus4=0, pc_plus8=4).
REQ-019 SHALL keep two states: IDLE (no buffer) and PENDING (buffer valid); IDLE->PENDING on stall and redirect; PENDING->IDLE on stall=0.

Reset
REQ-020 SHALL, on reset=1 at an edge, set pc=RESET_PC, redirect_pending=0, buffer=0, misalign_err=0, regardless of stall or redirect_valid.
REQ-021 SHALL discard any buffered redirect when reset is asserted mid-stall.

Configuration
REQ-022 SHALL use the macro PC_ALIGN_CHECK_EN.
REQ-023 SHALL, when PC_ALIGN_CHECK_EN is defined, force bits [1:0] of any applied target to 0 and pulse misalign_err (registered) for one cycle per misaligned target applied.
REQ-024 SHALL, when PC_ALIGN_CHECK_EN is undefined, load targets unmodified and tie misalign_err to 0.

Structure
REQ-025 SHALL place RESET_PC default value, PC width (32), and increment constants (4, 8) in the shared package mips_pkg.
REQ-026 SHALL instantiate one sub-module pc_incr (32-bit constant adder) for pc_plus4/pc_plus8.

Verification
REQ-027 SHALL cover: reset, then 3 free-run cycles -> pc = 3000, 3004, 3008, 300C.
REQ-028 SHALL cover: pc=3010, redirect_valid=1, target=3100, stall=0 -> next pc=3100, redirect_pending=0.
REQ-029 SHALL cover: stall=1 for 3 cycles, redirect 3200 in cycle 1 then 3300 in cycle 2 -> pc held, pending=1; on release pc=3300.
REQ-030 SHALL cover: pending=3300, stall drops with live redirect 3400 -> pc=3400, pending=0.
REQ-031 SHALL cover: pc=FFFF_FFFC, no redirect -> pc_plus8=4, next pc=0.
REQ-032 SHALL cover: with PC_ALIGN_CHECK_EN, target 3102 -> pc=3100, misalign_err=1 for one cycle; reset during stall with pending -> pc=3000, pending=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared constants and types for the fetch-side PC logic.
//   PC_W             : program counter width
//   RESET_PC_DEFAULT : default boot address loaded on reset
//   PC_INC4/PC_INC8  : sequential-fetch and link-value increments
//   pc_state_e       : redirect buffer state (IDLE = empty, PENDING = valid)
package mips_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [PC_W-1:0] PC_INC4          = 32'd4;
  localparam logic [PC_W-1:0] PC_INC8          = 32'd8;

  typedef enum logic {
    PC_IDLE    = 1'b0,
    PC_PENDING = 1'b1
  } pc_state_e;

endpackage : mips_pkg

// File: rtl/pc_incr.sv
// pc_incr -- constant adder producing the two PC-relative values the
// pipeline needs. Both sums wrap modulo 2^PC_W.
// Ports:
//   pc_i       : current PC
//   pc_plus4_o : pc + 4 (next sequential fetch)
//   pc_plus8_o : pc + 8 (jal/jalr link value, skips the delay slot)
module pc_incr
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] pc_plus8_o
);

  // Carry out of bit PC_W-1 is dropped on purpose: the address space wraps.
  assign pc_plus4_o = pc_i + PC_INC4;
  assign pc_plus8_o = pc_i + PC_INC8;

endmodule : pc_incr

// File: rtl/pc_unit.sv
// pc_unit -- program counter with stall hold and a one-entry redirect buffer.
// A redirect that arrives while the pipeline is stalled is remembered and
// applied on the first unstalled cycle; a live redirect on that cycle wins.
// Ports:
//   clk              : clock, all state changes on rising edge
//   reset            : synchronous active-high reset
//   stall            : hold the PC this cycle
//   redirect_valid   : redirect_target is a branch/jump target this cycle
//   redirect_target  : next fetch address when redirect_valid=1
//   pc               : current fetch address (registered)
//   pc_plus4         : pc + 4 (combinational)
//   pc_plus8         : pc + 8 (combinational, link value)
//   redirect_pending : a buffered redirect awaits stall release
//   misalign_err     : one-cycle pulse after a target with bits [1:0] != 0
//                      was applied
// Configuration:
//   PC_ALIGN_CHECK_EN : when defined, applied targets are forced word
//                       aligned and misalign_err reports the event; when
//                       undefined, targets load unmodified and misalign_err=0.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] pc_plus8,
  output logic            redirect_pending,
  output logic            misalign_err
);

  pc_state_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] buf_q;

  logic            apply_d;       // a target (live or buffered) loads this edge
  logic [PC_W-1:0] tgt_raw_d;     // target as presented
  logic [PC_W-1:0] tgt_applied_d; // target after optional alignment

  pc_incr u_pc_incr (
    .pc_i       (pc_q),
    .pc_plus4_o (pc_plus4),
    .pc_plus8_o (pc_plus8)
  );

  // Target selection: the live redirect has priority over the buffer.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    apply_d   = 1'b0;
    tgt_raw_d = buf_q;
    if (!stall) begin
      if (redirect_valid) begin
        apply_d   = 1'b1;
        tgt_raw_d = redirect_target;
      end else if (state_q == PC_PENDING) begin
        apply_d = 1'b1;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  assign tgt_applied_d = {tgt_raw_d[PC_W-1:2], 2'b00};
  assign misalign_d    = apply_d & (|tgt_raw_d[1:0]);
  assign misalign_err  = misalign_q;
`else
  assign tgt_applied_d = tgt_raw_d;
  assign misalign_err  = 1'b0;
`endif

  // Buffer FSM and PC register. Reset wins over stall and redirect, which
  // also discards any redirect buffered during a stall.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      state_q <= PC_IDLE;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
      if (stall) begin
        // Later redirects within one stall overwrite the earlier one.
        if (redirect_valid) begin
          buf_q   <= redirect_target;
          state_q <= PC_PENDING;
        end
      end else begin
        pc_q    <= apply_d ? tgt_applied_d : pc_plus4;
        buf_q   <= '0;
        state_q <= PC_IDLE;
      end
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == PC_PENDING);

endmodule : pc_unit
